// File: rtl/led_blinker.sv
// rtl/led_blinker.sv - multi-channel runtime-configurable LED driver
//
// One shared free-running counter drives NLEDS independent channels. Each
// channel is programmed through a single-cycle write port to off, on, blink
// (counter tap select) or PWM (compare against the low counter bits).
//
// Ports:
//   i_clk        system clock
//   i_reset      synchronous active-high reset
//   i_wr         config write strobe (single cycle, no back-pressure)
//   i_addr       target channel; addresses >= NLEDS match no channel
//   i_mode       0 = off, 1 = on, 2 = blink, 3 = PWM
//   i_rate       blink counter tap index (saturates at CW-1)
//   i_duty       PWM duty
//   o_led        registered LED outputs
//   o_heartbeat  registered copy of counter MSB

module led_blinker #(
    parameter int NLEDS = 4,
    parameter int CW    = 27,
    parameter int PWMW  = 8,
    parameter int AW    = $clog2(NLEDS)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr,
    input  logic [AW-1:0]    i_addr,
    input  logic [1:0]       i_mode,
    input  logic [4:0]       i_rate,
    input  logic [PWMW-1:0]  i_duty,
    output logic [NLEDS-1:0] o_led,
    output logic             o_heartbeat
);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_PWM   = 2'd3;
    localparam logic [4:0] RATE_MAX   = 5'(CW - 1);

    logic [CW-1:0] r_cnt;
    logic          r_heartbeat;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt       <= '0;
            r_heartbeat <= 1'b0;
        end else begin
            r_cnt       <= r_cnt + 1'b1;
            r_heartbeat <= r_cnt[CW-1];
        end
    end

    assign o_heartbeat = r_heartbeat;

    for (genvar k = 0; k < NLEDS; k++) begin : g_ch
        logic [1:0]      r_mode;
        logic [4:0]      r_rate;
        logic [PWMW-1:0] r_duty;
        logic            r_led;
        logic [4:0]      w_rate_eff;
        logic [CW-1:0]   w_tap;
        logic            w_next;

        // Saturate the tap so an oversized rate can never select past the MSB.
        assign w_rate_eff = (r_rate > RATE_MAX) ? RATE_MAX : r_rate;
        // A shift instead of a variable bit-select keeps the index width
        // independent of CW.
        assign w_tap      = r_cnt >> w_rate_eff;

        always_comb begin
            w_next = 1'b0;
            case (r_mode)
                MODE_OFF:   w_next = 1'b0;
                MODE_ON:    w_next = 1'b1;
                MODE_BLINK: w_next = w_tap[0];
                MODE_PWM:   w_next = (r_cnt[PWMW-1:0] < r_duty);
                default:    w_next = 1'b0;
            endcase
        end

        // The output uses the pre-edge config, so a write at edge E shows up
        // on o_led only from edge E+1.
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_mode <= MODE_BLINK;
                r_rate <= RATE_MAX;
                r_duty <= '0;
                r_led  <= 1'b0;
            end else begin
                r_led <= w_next;
                if (i_wr && (i_addr == AW'(k))) begin
                    r_mode <= i_mode;
                    r_rate <= i_rate;
                    r_duty <= i_duty;
                end
            end
        end

        assign o_led[k] = r_led;
    end

endmodule
